// File: rtl/fb_pixel_writer.sv
// Framebuffer write-port driver: clears the screen, then draws rasterised pixels.
// Optional double buffering via FB_DOUBLE_BUFFER_EN (adds a bank bit and display_bank_out).
module fb_pixel_writer #(
    parameter int WIDTH     = 1024,
    parameter int HEIGHT    = 720,
    parameter int TRIANGLES = 72,
    parameter int ADDR_W    = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              frame_start_in,
    input  logic [23:0]       clear_color_in,
    input  logic              tri_color_valid_in,
    input  logic [23:0]       tri_color_in,
    input  logic              pixel_valid_in,
    input  logic [19:0]       pixel_in,
    input  logic              last_in,
    output logic              ready_out,
    output logic              wr_en_out,
`ifdef FB_DOUBLE_BUFFER_EN
    output logic [ADDR_W:0]   wr_addr_out,
    output logic              display_bank_out,
`else
    output logic [ADDR_W-1:0] wr_addr_out,
`endif
    output logic [23:0]       wr_data_out,
    output logic              frame_done_out,
    output logic [19:0]       pixel_count_out,
    output logic              dropped_out
);

`ifdef FB_DOUBLE_BUFFER_EN
    localparam int OUT_AW = ADDR_W + 1;
`else
    localparam int OUT_AW = ADDR_W;
`endif
    localparam int TRI_W = $clog2(TRIANGLES + 1);
    localparam logic [TRI_W-1:0]  TRI_LIM   = TRI_W'(TRIANGLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [10:0]       X_LIM     = 11'(WIDTH);
    localparam logic [10:0]       Y_LIM     = 11'(HEIGHT);

    typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  clr_addr, clr_addr_n;
    logic [23:0]        clear_color, clear_color_n;
    logic [23:0]        tri_color, tri_color_n;
    logic [TRI_W-1:0]   tri_cnt, tri_cnt_n;
    logic               last_q;
    logic               last_rise;
    logic               wr_en_n, ready_n, done_n, dropped_n;
    logic [OUT_AW-1:0]  wr_addr_n;
    logic [23:0]        wr_data_n;
    logic [19:0]        pix_cnt_n;
    logic [9:0]         px_x, px_y;
    logic               in_bounds;
    logic [ADDR_W-1:0]  pix_addr;
    logic [OUT_AW-1:0]  sweep_full, pix_full;

    assign px_x      = pixel_in[19:10];
    assign px_y      = pixel_in[9:0];
    assign in_bounds = ({1'b0, px_x} < X_LIM) && ({1'b0, px_y} < Y_LIM);
    assign pix_addr  = ADDR_W'(px_x) + ADDR_W'(px_y) * ADDR_W'(WIDTH);
    assign last_rise = last_in & ~last_q;

    // Writes always target the bank not being displayed
`ifdef FB_DOUBLE_BUFFER_EN
    assign sweep_full = {~display_bank_out, clr_addr};
    assign pix_full   = {~display_bank_out, pix_addr};
`else
    assign sweep_full = clr_addr;
    assign pix_full   = pix_addr;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n       = state;
        clr_addr_n    = clr_addr;
        clear_color_n = clear_color;
        tri_color_n   = tri_color_valid_in ? tri_color_in : tri_color;
        tri_cnt_n     = tri_cnt;
        wr_en_n       = 1'b0;
        wr_addr_n     = wr_addr_out;
        wr_data_n     = wr_data_out;
        pix_cnt_n     = pixel_count_out;
        dropped_n     = dropped_out;
        unique case (state)
            IDLE: begin
                if (frame_start_in) begin
                    clear_color_n = clear_color_in;
                    clr_addr_n    = '0;
                    tri_cnt_n     = '0;
                    pix_cnt_n     = '0;
                    dropped_n     = 1'b0;
                    state_n       = CLEAR;
                end else if (pixel_valid_in) begin
                    dropped_n = 1'b1;
                end
            end
            CLEAR: begin
                wr_en_n    = 1'b1;
                wr_addr_n  = sweep_full;
                wr_data_n  = clear_color;
                clr_addr_n = clr_addr + ADDR_W'(1);
                if (pixel_valid_in) dropped_n = 1'b1;
                if (clr_addr == LAST_ADDR) state_n = DRAW;
            end
            DRAW: begin
                if (pixel_valid_in) begin
                    if (in_bounds) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = pix_full;
                        wr_data_n = tri_color;
                        if (pixel_count_out != '1)
                            pix_cnt_n = pixel_count_out + 20'd1;
                    end else begin
                        dropped_n = 1'b1;
                    end
                end
                if (last_rise) begin
                    tri_cnt_n = tri_cnt + TRI_W'(1);
                    if (tri_cnt_n == TRI_LIM) state_n = DONE;
                end
            end
            DONE: begin
                if (pixel_valid_in) dropped_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == DRAW);
        done_n  = (state_n == DONE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            clr_addr        <= '0;
            clear_color     <= '0;
            tri_color       <= '0;
            tri_cnt         <= '0;
            last_q          <= 1'b0;
            ready_out       <= 1'b0;
            wr_en_out       <= 1'b0;
            wr_addr_out     <= '0;
            wr_data_out     <= '0;
            frame_done_out  <= 1'b0;
            pixel_count_out <= '0;
            dropped_out     <= 1'b0;
        end else begin
            clr_addr        <= clr_addr_n;
            clear_color     <= clear_color_n;
            tri_color       <= tri_color_n;
            tri_cnt         <= tri_cnt_n;
            last_q          <= last_in;
            ready_out       <= ready_n;
            wr_en_out       <= wr_en_n;
            wr_addr_out     <= wr_addr_n;
            wr_data_out     <= wr_data_n;
            frame_done_out  <= done_n;
            pixel_count_out <= pix_cnt_n;
            dropped_out     <= dropped_n;
        end
    end

`ifdef FB_DOUBLE_BUFFER_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)      display_bank_out <= 1'b0;
        else if (done_n) display_bank_out <= ~display_bank_out;
    end
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer on an 8x4 screen with two triangles per frame.
module tb_fb_pixel_writer;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int T  = 2;
    localparam int AW = 5;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        frame_start_in;
    logic [23:0] clear_color_in;
    logic        tri_color_valid_in;
    logic [23:0] tri_color_in;
    logic        pixel_valid_in;
    logic [19:0] pixel_in;
    logic        last_in;
    logic        ready_out;
    logic        wr_en_out;
`ifdef FB_DOUBLE_BUFFER_EN
    logic [AW:0] wr_addr_out;
    logic        display_bank_out;
`else
    logic [AW-1:0] wr_addr_out;
`endif
    logic [23:0] wr_data_out;
    logic        frame_done_out;
    logic [19:0] pixel_count_out;
    logic        dropped_out;

    int n_cmp = 0;
    int n_err = 0;

    fb_pixel_writer #(.WIDTH(W), .HEIGHT(H), .TRIANGLES(T)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .frame_start_in     (frame_start_in),
        .clear_color_in     (clear_color_in),
        .tri_color_valid_in (tri_color_valid_in),
        .tri_color_in       (tri_color_in),
        .pixel_valid_in     (pixel_valid_in),
        .pixel_in           (pixel_in),
        .last_in            (last_in),
        .ready_out          (ready_out),
        .wr_en_out          (wr_en_out),
        .wr_addr_out        (wr_addr_out),
`ifdef FB_DOUBLE_BUFFER_EN
        .display_bank_out   (display_bank_out),
`endif
        .wr_data_out        (wr_data_out),
        .frame_done_out     (frame_done_out),
        .pixel_count_out    (pixel_count_out),
        .dropped_out        (dropped_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_wr(input int lim);
        int k = 0;
        while (!wr_en_out && k < lim) begin
            tick();
            k++;
        end
        chk("wr_start", 32'(wr_en_out), 1);
    endtask

    function automatic logic [19:0] px(input int x, input int y);
        return {x[9:0], y[9:0]};
    endfunction

    initial begin
        rst_in = 1'b1;
        frame_start_in = 1'b0;
        clear_color_in = '0;
        tri_color_valid_in = 1'b0;
        tri_color_in = '0;
        pixel_valid_in = 1'b0;
        pixel_in = '0;
        last_in = 1'b0;
        tick();
        tick();
        chk("rst_wr_en", 32'(wr_en_out), 0);
        chk("rst_ready", 32'(ready_out), 0);
        chk("rst_done", 32'(frame_done_out), 0);
        chk("rst_count", 32'(pixel_count_out), 0);
        chk("rst_dropped", 32'(dropped_out), 0);
        chk("rst_addr", 32'(wr_addr_out), 0);
        chk("rst_data", 32'(wr_data_out), 0);
        rst_in = 1'b0;
        tick();

        // Frame 1: full clear sweep
        clear_color_in = 24'h102030;
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        wait_wr(4);
        chk("clr_ready_low", 32'(ready_out), 0);
        for (int i = 0; i < W * H; i++) begin
            chk("clr_en", 32'(wr_en_out), 1);
            chk("clr_addr", 32'(wr_addr_out[AW-1:0]), i);
            chk("clr_data", 32'(wr_data_out), 32'h102030);
`ifdef FB_DOUBLE_BUFFER_EN
            chk("clr_bank1", 32'(wr_addr_out[AW]), 1);
`endif
            if (i < W * H - 1) tick();
        end
        tick();
        chk("draw_ready", 32'(ready_out), 1);
        chk("draw_idle_wr", 32'(wr_en_out), 0);

        // Draw path and colour latch ordering
        tri_color_valid_in = 1'b1;
        tri_color_in = 24'hFF0000;
        tick();
        tri_color_valid_in = 1'b0;
        pixel_valid_in = 1'b1;
        pixel_in = px(3, 2);
        tick();
        chk("px1_en", 32'(wr_en_out), 1);
        chk("px1_addr", 32'(wr_addr_out[AW-1:0]), 19);
        chk("px1_data", 32'(wr_data_out), 32'hFF0000);
        chk("px1_count", 32'(pixel_count_out), 1);
        tri_color_valid_in = 1'b1;
        tri_color_in = 24'h00FF00;
        pixel_in = px(0, 0);
        tick();
        tri_color_valid_in = 1'b0;
        chk("px2_addr", 32'(wr_addr_out[AW-1:0]), 0);
        chk("px2_old_color", 32'(wr_data_out), 32'hFF0000);
        pixel_in = px(7, 3);
        tick();
        chk("px3_en", 32'(wr_en_out), 1);
        chk("px3_addr", 32'(wr_addr_out[AW-1:0]), 31);
        chk("px3_new_color", 32'(wr_data_out), 32'h00FF00);
        chk("px3_count", 32'(pixel_count_out), 3);

        // Out-of-bounds pixels
        pixel_in = px(8, 0);
        tick();
        chk("oob_x_en", 32'(wr_en_out), 0);
        chk("oob_x_drop", 32'(dropped_out), 1);
        pixel_in = px(0, 4);
        tick();
        pixel_valid_in = 1'b0;
        chk("oob_y_en", 32'(wr_en_out), 0);
        chk("oob_count", 32'(pixel_count_out), 3);

        // Held last_in counts once
        last_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_done", 32'(frame_done_out), 0);
            chk("hold_ready", 32'(ready_out), 1);
        end
        last_in = 1'b0;
        tick();
        last_in = 1'b1;
        pixel_valid_in = 1'b1;
        pixel_in = px(1, 1);
        tick();
        last_in = 1'b0;
        pixel_valid_in = 1'b0;
        chk("last_px_en", 32'(wr_en_out), 1);
        chk("last_px_addr", 32'(wr_addr_out[AW-1:0]), 9);
        chk("last_px_data", 32'(wr_data_out), 32'h00FF00);
        chk("last_px_count", 32'(pixel_count_out), 4);
        chk("done_pulse", 32'(frame_done_out), 1);
        chk("done_ready", 32'(ready_out), 0);
`ifdef FB_DOUBLE_BUFFER_EN
        chk("bank_swap", 32'(display_bank_out), 1);
`endif

        // frame_start during DONE is dropped
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        chk("done_one_cycle", 32'(frame_done_out), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_restart_wr", 32'(wr_en_out), 0);
            chk("no_restart_ready", 32'(ready_out), 0);
        end

        // Frame 2: counters cleared, pixel in CLEAR dropped, reset at addr 10
        clear_color_in = 24'h0A0B0C;
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        chk("f2_drop_clr", 32'(dropped_out), 0);
        chk("f2_count_clr", 32'(pixel_count_out), 0);
        wait_wr(4);
        chk("f2_addr0", 32'(wr_addr_out[AW-1:0]), 0);
        chk("f2_data", 32'(wr_data_out), 32'h0A0B0C);
`ifdef FB_DOUBLE_BUFFER_EN
        chk("f2_bank0", 32'(wr_addr_out[AW]), 0);
`endif
        pixel_valid_in = 1'b1;
        tick();
        pixel_valid_in = 1'b0;
        chk("clr_px_drop", 32'(dropped_out), 1);
        begin
            int k = 0;
            while (wr_addr_out[AW-1:0] != 5'd10 && k < 20) begin
                tick();
                k++;
            end
        end
        chk("reach_addr10", 32'(wr_addr_out[AW-1:0]), 10);
        rst_in = 1'b1;
        #1;
        chk("async_rst_wr", 32'(wr_en_out), 0);
        tick();
        tick();
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_wr", 32'(wr_en_out), 0);
            chk("post_rst_ready", 32'(ready_out), 0);
        end
        chk("post_rst_drop", 32'(dropped_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Sink end of the rasteriser pixel stream. Consumes `{x,y}` pixel coordinates, a valid strobe and a per-triangle last flag; turns them into framebuffer write-port transactions (address, data, write enable).
- Each new frame first runs a clear sweep over the whole framebuffer. It then draws pixels in the colour latched for the current triangle, and signals frame completion after TRIANGLES last flags.
- Sits between the rasteriser and port A of the screen framebuffer BRAM.

Parameters:
- WIDTH, 1024, screen width in pixels; also the row stride for addresses.
- HEIGHT, 720, screen height in pixels.
- TRIANGLES, 72, number of triangle last flags per frame.
- ADDR_W, $clog2(WIDTH*HEIGHT), framebuffer address width.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- frame_start_in  input  1  single-cycle pulse; begins clear then draw
- clear_color_in  input  24  fill colour, sampled on frame_start_in
- tri_color_valid_in  input  1  latch tri_color_in as the current draw colour
- tri_color_in  input  24  RGB888 colour of the triangle being rasterised
- pixel_valid_in  input  1  pixel_in is a pixel to colour (level, one pixel per high cycle)
- pixel_in  input  20  {x[19:10], y[9:0]}
- last_in  input  1  rasteriser done with current triangle (level; rising edge counted)
- ready_out  output  1  high in DRAW; upstream may only dispatch triangles while high
- wr_en_out  output  1  framebuffer write enable
- wr_addr_out  output  ADDR_W  framebuffer write address
- wr_data_out  output  24  framebuffer write data
- frame_done_out  output  1  single-cycle pulse at end of frame
- pixel_count_out  output  20  pixels written in DRAW this frame (saturating)
- dropped_out  output  1  sticky: a pixel was discarded this frame

Behaviour:
- Reset (async, active-high) values:
  - state = IDLE.
  - All outputs 0.
  - Colour registers 0.
  - Triangle counter 0.
  - last_in edge register 0.
- All outputs are registered.
- States:
  - IDLE: on frame_start_in, latch clear_color_in, zero pixel_count_out, dropped_out and the triangle counter, then go to CLEAR.
  - CLEAR: each cycle, wr_en_out=1, wr_data_out=clear colour, wr_addr_out counts 0..WIDTH*HEIGHT-1. Leave to DRAW the cycle after the final address is issued.
  - DRAW: ready_out=1. On pixel_valid_in, the next cycle carries wr_en_out=1, wr_addr_out=x+y*WIDTH (computed in ADDR_W bits) and wr_data_out=current triangle colour. Latency is exactly 1 cycle; throughput is 1 pixel/cycle with no stalls.
  - DONE: frame_done_out=1 for one cycle, then go to IDLE.
- Bounds: a pixel with x>=WIDTH or y>=HEIGHT:
  - issues no write;
  - sets dropped_out;
  - does not increment pixel_count_out.
- pixel_count_out increments per accepted write and saturates at 2^20-1.
- Colour latch:
  - tri_color_valid_in in any state updates the current colour.
  - If it coincides with pixel_valid_in, the pixel uses the old colour; the new colour applies from the next pixel.
- Triangle counting: a last_in rising edge in DRAW increments the triangle counter. When the counter reaches TRIANGLES, go to DONE. A pixel_valid_in in that same cycle is still written.
- Non-DRAW pixels: pixel_valid_in in IDLE, CLEAR or DONE is discarded and sets dropped_out.
- frame_start_in:
  - Ignored outside IDLE.
  - frame_start_in while in DONE is ignored, not queued.
- Reset mid-CLEAR or mid-DRAW returns to IDLE with no further writes. wr_en_out is low from reset assertion.
- Simultaneous pixel_valid_in and last_in rising edge: the pixel is written and the triangle is counted.

Optional Feature:
- Macro: FB_DOUBLE_BUFFER_EN.
- Defined:
  - wr_addr_out widens to ADDR_W+1; its MSB is the back-buffer bank.
  - Adds output display_bank_out (1 bit, reset 0), which is always the opposite bank.
  - CLEAR and DRAW write only the back bank.
  - On the DONE cycle the banks swap: display_bank_out toggles in the same cycle frame_done_out pulses.
- Undefined: single buffer; wr_addr_out is ADDR_W bits; no display_bank_out port.

Test Plan:
- Clear sweep. Bench parameters WIDTH=8, HEIGHT=4, TRIANGLES=2. frame_start_in with clear_color_in=24'h102030 -> 32 consecutive writes, addr 0..31, data 102030, then ready_out=1.
- Draw path. In DRAW: tri_color_in=FF0000 latched, then pixel_in={x=3,y=2} -> next cycle wr_en_out=1, wr_addr_out=19, wr_data_out=FF0000, pixel_count_out=1.
- Out of bounds. Pixel {x=8,y=0}, then pixel {x=0,y=4} -> no writes, dropped_out=1, pixel_count_out unchanged.
- Last edge plus simultaneous pixel. last_in held high 5 cycles -> counted once. Second last_in rising edge together with pixel {1,1} -> write to addr 9, then frame_done_out pulses exactly one cycle and ready_out=0.
- Reset mid-clear. rst_in asserted mid-CLEAR at addr 10 -> wr_en_out=0 immediately; after release, state is IDLE and no writes occur until frame_start_in.
- Double buffer (FB_DOUBLE_BUFFER_EN defined). Frame 1 writes carry MSB=1 and display_bank_out toggles to 1 at frame_done_out. Frame 2 writes carry MSB=0.
